sync_debounce: RTL and testbench

//  Input-conditioning stage feeding a register's d input from an asynchronous, bouncy source (pin/button).
//  - Synchronises din through a flop chain.
//  - Filters glitches with a stability counter; produces a clean level q.
//  - Produces one-cycle rise/fall pulses.
//  - Downstream flops sample q directly; no further synchronisation needed.

---
 rtl/dff_pkg.sv | 11 +
 rtl/sync_chain.sv | 28 ++
 rtl/sync_debounce.sv | 129 ++++++++++++
 tb/tb_sync_debounce.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared types for the debounce block: the four resting/checking states.
package dff_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } deb_state_t;

endpackage

// File: rtl/sync_chain.sv
// Flop shift chain that brings an asynchronous 1-bit input into the clk domain.
// The output is the last stage; the first stage may go metastable.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input in at bit 0; bit STAGES-1 is the synchronised value.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Chain register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain_q <= '0;
    else          chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronise a bouncy asynchronous input, accept a level change only after
// DEBOUNCE_CYCLES consecutive agreeing synced samples, and emit one-cycle
// rise/fall pulses. All outputs come straight from flops.
//
// Handshake: none. din is free-running and asynchronous; q/rise/fall/busy
// are plain registered levels/pulses valid every cycle after reset.
module sync_debounce
  import dff_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  output logic       q,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output deb_state_t dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("sync_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  logic       din_s;
  deb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       q_q, q_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       busy_q, busy_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (din),
    .q       (din_s)
  );

  // Next-state: count consecutive opposite samples; any agreeing sample aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (din_s) begin
          state_d = S_RISE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      S_RISE_CHK: begin
        if (!din_s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          q_d     = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!din_s) begin
          state_d = S_FALL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      S_FALL_CHK: begin
        if (din_s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
    busy_d = (state_d == S_RISE_CHK) || (state_d == S_FALL_CHK);
  end

  // FSM, counter and registered outputs; reset discards any pending candidate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign q         = q_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed scenarios with literal expectations plus
// randomized din checked every cycle against a run-length reference model.
module tb_sync_debounce;
  import dff_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;
  always #5 clk = ~clk;

  logic       q, rise, fall, busy;
  deb_state_t dbg_state;

  sync_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .q         (q),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // din_s is din delayed by SYNC clock samples; q flips once DEB consecutive
  // delayed samples disagree with it.
  bit din_hist[$];
  bit m_q, m_rise, m_fall;
  int run;

  initial begin
    for (int i = 0; i < SYNC; i++) din_hist.push_back(1'b0);
  end

  always @(posedge clk or negedge reset_n) begin
    bit ds;
    if (!reset_n) begin
      din_hist = {};
      for (int i = 0; i < SYNC; i++) din_hist.push_back(1'b0);
      m_q = 0; m_rise = 0; m_fall = 0; run = 0;
    end else begin
      ds = din_hist[SYNC-1];
      din_hist.push_front(din);
      void'(din_hist.pop_back());
      m_rise = 0;
      m_fall = 0;
      if (ds != m_q) begin
        run++;
        if (run == DEB) begin
          m_q    = ds;
          m_rise = ds;
          m_fall = !ds;
          run    = 0;
        end
      end else begin
        run = 0;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [3:0] exp_q[$];
  int rise_cnt = 0;
  int fall_cnt = 0;

  always @(negedge clk) begin
    logic [3:0] e;
    deb_state_t es;
    e = {m_q, m_rise, m_fall, (run > 0)};
    exp_q.push_back(e);
    e = exp_q.pop_front();
    chk("cyc_q",    int'(q),    int'(e[3]));
    chk("cyc_rise", int'(rise), int'(e[2]));
    chk("cyc_fall", int'(fall), int'(e[1]));
    chk("cyc_busy", int'(busy), int'(e[0]));
    chk("cyc_both_pulses", int'(rise & fall), 0);
    es = e[3] ? (e[0] ? S_FALL_CHK : S_HIGH) : (e[0] ? S_RISE_CHK : S_LOW);
    chk("cyc_state", int'(dbg_state), int'(es));
    if (rise === 1'b1) rise_cnt++;
    if (fall === 1'b1) fall_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int r0, f0;
    bit  seen_busy;
    int  len;

    // 1. reset with din high; then q rises six edges after release
    ticks(2);
    din = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_rise", int'(rise), 0);
    chk("rst_fall", int'(fall), 0);
    chk("rst_busy", int'(busy), 0);
    ticks(3);
    reset_n = 1'b1;
    ticks(5);
    chk("rst_rel_q_e5", int'(q), 0);
    tick();
    chk("rst_rel_q_e6", int'(q), 1);
    chk("rst_rel_rise_e6", int'(rise), 1);
    ticks(4);

    // 4. clean fall from q=1
    r0 = rise_cnt;
    din = 1'b0;
    ticks(5);
    chk("fall_q_e5", int'(q), 1);
    tick();
    chk("fall_q_e6", int'(q), 0);
    chk("fall_pulse_e6", int'(fall), 1);
    chk("fall_rise_e6", int'(rise), 0);
    tick();
    chk("fall_pulse_e7", int'(fall), 0);
    chk("fall_no_rise", rise_cnt - r0, 0);
    ticks(4);

    // 2. clean rise
    din = 1'b1;
    ticks(2);
    chk("rise_busy_e2", int'(busy), 0);
    for (int e = 3; e <= 5; e++) begin
      tick();
      chk($sformatf("rise_busy_e%0d", e), int'(busy), 1);
      chk($sformatf("rise_q_e%0d", e), int'(q), 0);
    end
    tick();
    chk("rise_q_e6", int'(q), 1);
    chk("rise_pulse_e6", int'(rise), 1);
    chk("rise_busy_e6", int'(busy), 0);
    tick();
    chk("rise_pulse_e7", int'(rise), 0);
    din = 1'b0;
    ticks(10);
    chk("rise_back_low", int'(q), 0);

    // 3. glitch of three cycles
    r0 = rise_cnt; f0 = fall_cnt; seen_busy = 0;
    din = 1'b1;
    ticks(3);
    din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) seen_busy = 1;
      chk("glitch_q", int'(q), 0);
    end
    chk("glitch_busy_seen", int'(seen_busy), 1);
    chk("glitch_no_rise", rise_cnt - r0, 0);
    chk("glitch_no_fall", fall_cnt - f0, 0);

    // 5. reset while a rise is being counted
    din = 1'b1;
    ticks(4);
    chk("midrst_busy_before", int'(busy), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_state", int'(dbg_state), int'(S_LOW));
    chk("midrst_busy", int'(busy), 0);
    tick();
    reset_n = 1'b1;
    ticks(5);
    chk("midrst_q_e5", int'(q), 0);
    tick();
    chk("midrst_q_e6", int'(q), 1);
    chk("midrst_rise_e6", int'(rise), 1);
    din = 1'b0;
    ticks(10);

    // 6. bounce every 2 cycles for 20 cycles, then settle high
    r0 = rise_cnt; f0 = fall_cnt;
    for (int i = 0; i < 10; i++) begin
      din = ~din;
      ticks(2);
      chk("bounce_q", int'(q), 0);
    end
    chk("bounce_no_rise", rise_cnt - r0, 0);
    din = 1'b1;
    ticks(12);
    chk("bounce_one_rise", rise_cnt - r0, 1);
    chk("bounce_no_fall", fall_cnt - f0, 0);
    chk("bounce_final_q", int'(q), 1);

    // random segments with occasional reset pulses
    for (int s = 0; s < 200; s++) begin
      din = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      ticks(len);
    end
    din = 1'b0;
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
